// File: rtl/vector_pe.sv
// -----------------------------------------------------------------------------
// vector_pe
// Multi-lane signed dot-product processing element. Each accepted beat
// multiplies LANES neuron/weight pairs, reduces the products and accumulates
// the sum across a ctl-delimited sequence (start/continue/end or single).
// The result of an end/single beat is emitted, optionally saturated to the
// signed OW range, through a valid/ready port with full back-pressure.
//
// Ports:
//   clk     rising-edge clock
//   rst_n   synchronous active-low reset
//   neuron  LANES x DW packed signed elements, lane i at [i*DW +: DW]
//   weight  LANES x DW packed signed elements, same packing
//   ctl     beat type: 00 start, 01 continue, 10 single, 11 end
//   vld_i   input beat valid
//   rdy_o   input ready (beat accepted on vld_i && rdy_o)
//   result  signed OW-bit result (saturated when SAT=1, wrapped when SAT=0)
//   ovf_o   accumulated value was outside the signed OW range
//   vld_o   result valid, held until accepted
//   rdy_i   downstream ready
// -----------------------------------------------------------------------------
module vector_pe #(
  parameter int DW    = 16,
  parameter int LANES = 4,
  parameter int GUARD = 8,
  parameter int OW    = 32,
  parameter int SAT   = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [LANES*DW-1:0]   neuron,
  input  logic [LANES*DW-1:0]   weight,
  input  logic [1:0]            ctl,
  input  logic                  vld_i,
  output logic                  rdy_o,
  output logic [OW-1:0]         result,
  output logic                  ovf_o,
  output logic                  vld_o,
  input  logic                  rdy_i
);

  localparam int PW   = 2 * DW;
  localparam int ACCW = 2 * DW + $clog2(LANES) + GUARD;

  localparam logic [1:0] CTL_START  = 2'b00;
  localparam logic [1:0] CTL_CONT   = 2'b01;
  localparam logic [1:0] CTL_SINGLE = 2'b10;
  localparam logic [1:0] CTL_END    = 2'b11;

  // The value fits in signed OW bits only if every bit from OW-1 upward is a
  // copy of the sign bit.
  function automatic logic is_out_of_range(input logic [ACCW-1:0] v);
    logic [ACCW-OW:0] hi;
    hi = v[ACCW-1:OW-1];
    return !((&hi) || !(|hi));
  endfunction

  // Narrow the accumulator to OW bits: clamp toward the sign when saturating,
  // otherwise keep the low bits.
  function automatic logic [OW-1:0] fit_result(input logic [ACCW-1:0] v);
    logic [OW-1:0] r;
    if ((SAT != 0) && is_out_of_range(v)) begin
      if (v[ACCW-1]) begin
        r = {1'b1, {(OW-1){1'b0}}};
      end else begin
        r = {1'b0, {(OW-1){1'b1}}};
      end
    end else begin
      r = v[OW-1:0];
    end
    return r;
  endfunction

  logic                  w_stall;
  logic [LANES*PW-1:0]   w_prod;
  logic [ACCW-1:0]       w_sum;
  logic [ACCW-1:0]       w_acc_next;
  logic                  w_emit;

  logic                  r_s1_vld;
  logic [1:0]            r_s1_ctl;
  logic [LANES*PW-1:0]   r_s1_prod;
  logic                  r_s2_vld;
  logic [1:0]            r_s2_ctl;
  logic [ACCW-1:0]       r_s2_sum;
  logic [ACCW-1:0]       r_acc;
  logic [OW-1:0]         r_result;
  logic                  r_ovf;
  logic                  r_vld_o;

  // A presented-but-unaccepted result freezes the whole pipeline.
  assign w_stall = r_vld_o && !rdy_i;
  assign rdy_o   = !w_stall;
  assign result  = r_result;
  assign ovf_o   = r_ovf;
  assign vld_o   = r_vld_o;

  // Per-lane full-precision signed products.
  always_comb begin
    w_prod = '0;
    for (int i = 0; i < LANES; i++) begin
      w_prod[i*PW +: PW] = PW'($signed(neuron[i*DW +: DW])) *
                           PW'($signed(weight[i*DW +: DW]));
    end
  end

  // Reduce the registered lane products, sign-extended to accumulator width.
  always_comb begin
    w_sum = '0;
    for (int i = 0; i < LANES; i++) begin
      w_sum = w_sum + ACCW'($signed(r_s1_prod[i*PW +: PW]));
    end
  end

  // Next accumulator value: start/single reload, continue/end add on.
  always_comb begin
    case (r_s2_ctl)
      CTL_START, CTL_SINGLE: w_acc_next = r_s2_sum;
      CTL_CONT,  CTL_END:    w_acc_next = r_acc + r_s2_sum;
      default:               w_acc_next = r_acc + r_s2_sum;
    endcase
  end

  // Only end/single beats landing in S3 produce an output.
  always_comb begin
    if (r_s2_vld) begin
      w_emit = r_s2_ctl[1];
    end else begin
      w_emit = 1'b0;
    end
  end

  // Stage 1: capture the lane products and beat control.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s1_vld  <= 1'b0;
      r_s1_ctl  <= 2'b00;
      r_s1_prod <= '0;
    end else if (!w_stall) begin
      r_s1_vld  <= vld_i;
      r_s1_ctl  <= ctl;
      r_s1_prod <= w_prod;
    end else begin
      r_s1_vld  <= r_s1_vld;
      r_s1_ctl  <= r_s1_ctl;
      r_s1_prod <= r_s1_prod;
    end
  end

  // Stage 2: capture the reduced sum and beat control.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s2_vld <= 1'b0;
      r_s2_ctl <= 2'b00;
      r_s2_sum <= '0;
    end else if (!w_stall) begin
      r_s2_vld <= r_s1_vld;
      r_s2_ctl <= r_s1_ctl;
      r_s2_sum <= w_sum;
    end else begin
      r_s2_vld <= r_s2_vld;
      r_s2_ctl <= r_s2_ctl;
      r_s2_sum <= r_s2_sum;
    end
  end

  // Stage 3: accumulator update for every valid beat leaving S2.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_acc <= '0;
    end else if (!w_stall && r_s2_vld) begin
      r_acc <= w_acc_next;
    end else begin
      r_acc <= r_acc;
    end
  end

  // Output register. When not stalled any presented result is being taken,
  // so vld_o either drops or is immediately refilled by a new end/single beat.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_result <= '0;
      r_ovf    <= 1'b0;
      r_vld_o  <= 1'b0;
    end else if (!w_stall) begin
      if (w_emit) begin
        r_result <= fit_result(w_acc_next);
        r_ovf    <= is_out_of_range(w_acc_next);
        r_vld_o  <= 1'b1;
      end else begin
        r_result <= r_result;
        r_ovf    <= r_ovf;
        r_vld_o  <= 1'b0;
      end
    end else begin
      r_result <= r_result;
      r_ovf    <= r_ovf;
      r_vld_o  <= r_vld_o;
    end
  end

endmodule

// File: tb/tb_vector_pe.sv
// -----------------------------------------------------------------------------
// tb_vector_pe
// Self-checking bench for vector_pe. Two instances share the stimulus: one
// saturating (SAT=1) and one wrapping (SAT=0). Expected results are pushed to
// a scoreboard queue when a beat is accepted and compared when the output
// handshake happens.
// -----------------------------------------------------------------------------
module tb_vector_pe;

  localparam int DW    = 16;
  localparam int LANES = 4;
  localparam int OW    = 32;

  logic                clk;
  logic                rst_n;
  logic [LANES*DW-1:0] neuron;
  logic [LANES*DW-1:0] weight;
  logic [1:0]          ctl;
  logic                vld_i;
  logic                rdy_i;

  logic                rdy_o_s, ovf_s, vld_o_s;
  logic [OW-1:0]       res_s;
  logic                rdy_o_w, ovf_w, vld_o_w;
  logic [OW-1:0]       res_w;

  typedef struct {
    logic [31:0] sat;
    logic [31:0] wrp;
    logic        ovf;
  } exp_t;

  exp_t   exp_q[$];
  longint m_acc;
  int     n_cmp;
  int     n_err;

  vector_pe #(.DW(DW), .LANES(LANES), .GUARD(8), .OW(OW), .SAT(1)) dut_sat (
    .clk(clk), .rst_n(rst_n), .neuron(neuron), .weight(weight), .ctl(ctl),
    .vld_i(vld_i), .rdy_o(rdy_o_s), .result(res_s), .ovf_o(ovf_s),
    .vld_o(vld_o_s), .rdy_i(rdy_i)
  );

  vector_pe #(.DW(DW), .LANES(LANES), .GUARD(8), .OW(OW), .SAT(0)) dut_wrap (
    .clk(clk), .rst_n(rst_n), .neuron(neuron), .weight(weight), .ctl(ctl),
    .vld_i(vld_i), .rdy_o(rdy_o_w), .result(res_w), .ovf_o(ovf_w),
    .vld_o(vld_o_w), .rdy_i(rdy_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] pack4(input int a, input int b, input int c, input int d);
    return {d[15:0], c[15:0], b[15:0], a[15:0]};
  endfunction

  // Scoreboard: compare on every output handshake, seen at the falling edge.
  always @(negedge clk) begin
    if (rst_n && vld_o_s && rdy_i) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL sb_unexpected: got result=%h with no expected entry", res_s);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        n_cmp++;
        if (res_s !== e.sat || ovf_s !== e.ovf) begin
          n_err++;
          $display("FAIL sb_sat: got result=%h ovf=%b, want result=%h ovf=%b",
                   res_s, ovf_s, e.sat, e.ovf);
        end
        n_cmp++;
        if (res_w !== e.wrp || ovf_w !== e.ovf || vld_o_w !== 1'b1) begin
          n_err++;
          $display("FAIL sb_wrap: got result=%h ovf=%b vld=%b, want result=%h ovf=%b vld=1",
                   res_w, ovf_w, vld_o_w, e.wrp, e.ovf);
        end
      end
    end
  end

  // Drive one beat, wait for acceptance, update the reference model.
  task automatic send_beat(input logic [63:0] n, input logic [63:0] w, input logic [1:0] c);
    bit     acc_ok;
    int     t;
    longint s;
    neuron = n;
    weight = w;
    ctl    = c;
    vld_i  = 1'b1;
    t      = 0;
    acc_ok = 1'b0;
    do begin
      @(negedge clk);
      acc_ok = rdy_o_s;
      @(posedge clk);
      #1;
      t++;
    end while (!acc_ok && t < 200);
    vld_i = 1'b0;
    if (!acc_ok) begin
      n_cmp++;
      n_err++;
      $display("FAIL send_timeout: got rdy_o=0 for %0d cycles, want acceptance", t);
    end else begin
      s = 0;
      for (int i = 0; i < LANES; i++) begin
        s += longint'($signed(n[i*16 +: 16])) * longint'($signed(w[i*16 +: 16]));
      end
      if (c == 2'b00 || c == 2'b10) m_acc = s;
      else                          m_acc = m_acc + s;
      if (c[1]) begin
        exp_t e;
        e.ovf = (m_acc > 64'sd2147483647) || (m_acc < -64'sd2147483648);
        e.wrp = m_acc[31:0];
        if (m_acc > 64'sd2147483647)       e.sat = 32'h7FFF_FFFF;
        else if (m_acc < -64'sd2147483648) e.sat = 32'h8000_0000;
        else                               e.sat = m_acc[31:0];
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 100) begin
      @(negedge clk);
      t++;
    end
    repeat (4) @(negedge clk);
    @(posedge clk);
    #1;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: got %0d outputs outstanding, want 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    rst_n  = 1'b0;
    vld_i  = 1'b0;
    rdy_i  = 1'b1;
    ctl    = 2'b00;
    neuron = '0;
    weight = '0;
    m_acc  = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (vld_o_s !== 1'b0 || vld_o_w !== 1'b0) begin
      n_err++; $display("FAIL reset_vld: got %b/%b, want 0/0", vld_o_s, vld_o_w);
    end
    n_cmp++;
    if (res_s !== 32'h0 || res_w !== 32'h0) begin
      n_err++; $display("FAIL reset_result: got %h/%h, want 0/0", res_s, res_w);
    end
    n_cmp++;
    if (ovf_s !== 1'b0 || ovf_w !== 1'b0) begin
      n_err++; $display("FAIL reset_ovf: got %b/%b, want 0/0", ovf_s, ovf_w);
    end
    n_cmp++;
    if (rdy_o_s !== 1'b1 || rdy_o_w !== 1'b1) begin
      n_err++; $display("FAIL reset_rdy: got %b/%b, want 1/1", rdy_o_s, rdy_o_w);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_single();
    logic exp_v[4];
    exp_v[0] = 1'b0; exp_v[1] = 1'b0; exp_v[2] = 1'b1; exp_v[3] = 1'b0;
    rdy_i = 1'b1;
    send_beat(pack4(1, 2, 3, 4), pack4(5, 6, 7, 8), 2'b10);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      n_cmp++;
      if (vld_o_s !== exp_v[k]) begin
        n_err++;
        $display("FAIL single_latency[%0d]: got vld_o=%b, want %b", k, vld_o_s, exp_v[k]);
      end
      if (k == 2) begin
        n_cmp++;
        if (res_s !== 32'd70 || ovf_s !== 1'b0) begin
          n_err++;
          $display("FAIL single_value: got %0d ovf=%b, want 70 ovf=0", $signed(res_s), ovf_s);
        end
      end
    end
    wait_drain();
  endtask

  task automatic test_sequence();
    rdy_i = 1'b1;
    send_beat(pack4(1, 1, 1, 1), pack4(1, 1, 1, 1), 2'b00);
    send_beat(pack4(1, 1, 1, 1), pack4(1, 1, 1, 1), 2'b01);
    send_beat(pack4(1, 1, 1, 1), pack4(1, 1, 1, 1), 2'b11);
    send_beat(pack4(-1, -1, -1, -1), pack4(2, 2, 2, 2), 2'b00);
    send_beat(pack4(-1, -1, -1, -1), pack4(2, 2, 2, 2), 2'b01);
    send_beat(pack4(-1, -1, -1, -1), pack4(2, 2, 2, 2), 2'b11);
    wait_drain();
  endtask

  task automatic test_saturation();
    rdy_i = 1'b1;
    send_beat(pack4(-32768, -32768, -32768, -32768), pack4(-32768, -32768, -32768, -32768), 2'b00);
    send_beat(pack4(-32768, -32768, -32768, -32768), pack4(-32768, -32768, -32768, -32768), 2'b11);
    wait_drain();
    send_beat(pack4(-32768, -32768, -32768, -32768), pack4(32767, 32767, 32767, 32767), 2'b00);
    send_beat(pack4(-32768, -32768, -32768, -32768), pack4(32767, 32767, 32767, 32767), 2'b11);
    wait_drain();
  endtask

  task automatic test_back_pressure();
    rdy_i = 1'b1;
    fork
      begin
        for (int v = 1; v <= 8; v++) begin
          send_beat(pack4(v, 0, 0, 0), pack4(1, 0, 0, 0), 2'b10);
        end
      end
      begin
        repeat (5) @(posedge clk);
        #1;
        rdy_i = 1'b0;
        for (int k = 0; k < 5; k++) begin
          @(negedge clk);
          n_cmp++;
          if (rdy_o_s !== 1'b0) begin
            n_err++;
            $display("FAIL bp_rdy_o[%0d]: got %b, want 0", k, rdy_o_s);
          end
        end
        @(posedge clk);
        #1;
        rdy_i = 1'b1;
      end
    join
    wait_drain();
  endtask

  task automatic test_zero_bubble();
    logic        exp_v[4];
    logic [31:0] exp_r[4];
    exp_v[0] = 1'b0; exp_v[1] = 1'b1; exp_v[2] = 1'b1; exp_v[3] = 1'b0;
    exp_r[1] = 32'd12; exp_r[2] = 32'd17;
    rdy_i = 1'b1;
    send_beat(pack4(3, 0, 0, 0), pack4(4, 0, 0, 0), 2'b10);
    send_beat(pack4(5, 0, 0, 0), pack4(1, 0, 0, 0), 2'b11);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      n_cmp++;
      if (vld_o_s !== exp_v[k]) begin
        n_err++;
        $display("FAIL zb_vld[%0d]: got %b, want %b", k, vld_o_s, exp_v[k]);
      end
      if (exp_v[k]) begin
        n_cmp++;
        if (res_s !== exp_r[k]) begin
          n_err++;
          $display("FAIL zb_result[%0d]: got %0d, want %0d", k, res_s, exp_r[k]);
        end
      end
    end
    wait_drain();
  endtask

  task automatic test_reset_mid();
    rdy_i = 1'b0;
    send_beat(pack4(7, 0, 0, 0), pack4(1, 0, 0, 0), 2'b10);
    send_beat(pack4(8, 0, 0, 0), pack4(1, 0, 0, 0), 2'b00);
    send_beat(pack4(9, 0, 0, 0), pack4(1, 0, 0, 0), 2'b01);
    @(negedge clk);
    n_cmp++;
    if (rdy_o_s !== 1'b0 || vld_o_s !== 1'b1) begin
      n_err++;
      $display("FAIL rm_stall: got rdy_o=%b vld_o=%b, want 0/1", rdy_o_s, vld_o_s);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    exp_q.delete();
    m_acc = 0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (vld_o_s !== 1'b0 || res_s !== 32'h0 || ovf_s !== 1'b0 || rdy_o_s !== 1'b1) begin
      n_err++;
      $display("FAIL rm_after: got vld=%b res=%h ovf=%b rdy=%b, want 0/0/0/1",
               vld_o_s, res_s, ovf_s, rdy_o_s);
    end
    @(posedge clk);
    #1;
    rdy_i = 1'b1;
    send_beat(pack4(2, 2, 0, 0), pack4(3, 3, 0, 0), 2'b11);
    wait_drain();
  endtask

  task automatic test_random();
    fork
      begin
        for (int i = 0; i < 16; i++) begin
          send_beat({16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom)},
                    {16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom)},
                    2'($urandom_range(0, 3)));
        end
      end
      begin
        for (int k = 0; k < 40; k++) begin
          @(posedge clk);
          #1;
          rdy_i = ($urandom_range(0, 3) != 0);
        end
        rdy_i = 1'b1;
      end
    join
    send_beat(pack4(1, 0, 0, 0), pack4(1, 0, 0, 0), 2'b11);
    wait_drain();
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    test_reset();
    test_single();
    test_sequence();
    test_saturation();
    test_back_pressure();
    test_zero_bubble();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
